// File: rtl/jk_count_monitor_pkg.sv
// ============================================================================
// jk_count_monitor_pkg: shared states, step classes and default widths
// Rev 1.0
// ============================================================================
`default_nettype none

package jk_count_monitor_pkg;

  localparam int c_cnt_w  = 4;
  localparam int c_ext_w  = 8;
  localparam int c_lock_n = 2;

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

endpackage

`default_nettype wire

// File: rtl/jk_count_monitor_count_step_decode.sv
// ============================================================================
// count_step_decode: classifies one counter step and flags wrap-around
// Rev 1.0
// ============================================================================
`default_nettype none

module count_step_decode
  import jk_count_monitor_pkg::*;
#(
  parameter int CNT_W = c_cnt_w
) (
  input  logic [CNT_W-1:0] q_prev,
  input  logic [CNT_W-1:0] q_s,
  input  logic             ok_s,
  output step_t            step,
  output logic             wrap_up,
  output logic             wrap_down
);

  logic [CNT_W-1:0] w_delta;

  assign w_delta = q_s - q_prev;

  // An inconsistent sample is never a legal step, whatever its value.
  always_comb begin
    step = STEP_ILLEGAL;
    if (ok_s) begin
      if (w_delta == '0)                step = STEP_HOLD;
      else if (w_delta == CNT_W'(1))    step = STEP_UP;
      else if (w_delta == '1)           step = STEP_DOWN;
    end
  end

  assign wrap_up   = (step == STEP_UP)   && (q_prev == '1);
  assign wrap_down = (step == STEP_DOWN) && (q_prev == '0);

endmodule

`default_nettype wire

// File: rtl/jk_count_monitor.sv
// ============================================================================
// jk_count_monitor: validates JK counter samples, extends count, buffers snapshots
// Rev 1.0
// ============================================================================
`default_nettype none

module jk_count_monitor
  import jk_count_monitor_pkg::*;
#(
  parameter int CNT_W  = c_cnt_w,
  parameter int EXT_W  = c_ext_w,
  parameter int LOCK_N = c_lock_n
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       q,
  input  logic [CNT_W-1:0]       q_bar,
  input  logic                   snap_req,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [EXT_W+CNT_W-1:0] out_data,
  output logic [EXT_W+CNT_W-1:0] count_ext,
  output logic                   wrap_pulse,
  output logic                   locked,
  output logic                   error,
  output logic                   overrun
);

  localparam int LOCK_W = $clog2(LOCK_N + 1);

  logic [CNT_W-1:0]       r_q_s;
  logic [CNT_W-1:0]       r_q_prev;
  logic                   r_ok_s;
  state_t                 r_state;
  logic [LOCK_W-1:0]      r_lock_cnt;
  logic [EXT_W-1:0]       r_wrap_cnt;
  logic                   r_error;
  logic                   r_out_valid;
  logic [EXT_W+CNT_W-1:0] r_out_data;
  logic                   r_overrun;

  step_t                  w_step;
  logic                   w_wrap_up;
  logic                   w_wrap_down;
  state_t                 w_next_state;
  logic [LOCK_W-1:0]      w_next_lock;
  logic [EXT_W-1:0]       w_next_wrap;
  logic                   w_set_error;

  count_step_decode #(
    .CNT_W (CNT_W)
  ) u_step_decode (
    .q_prev    (r_q_prev),
    .q_s       (r_q_s),
    .ok_s      (r_ok_s),
    .step      (w_step),
    .wrap_up   (w_wrap_up),
    .wrap_down (w_wrap_down)
  );

  // Samples: an X/Z compare fails the if and lands on the inconsistent branch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q_s    <= '0;
      r_q_prev <= '0;
      r_ok_s   <= 1'b0;
    end else begin
      r_q_s    <= q;
      r_q_prev <= r_q_s;
      if (q == ~q_bar) r_ok_s <= 1'b1;
      else             r_ok_s <= 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_lock  = r_lock_cnt;
    w_next_wrap  = r_wrap_cnt;
    w_set_error  = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (!r_ok_s) begin
          w_next_lock = '0;
        end else if (r_lock_cnt == LOCK_W'(LOCK_N - 1)) begin
          w_next_state = ST_RUN;
          w_next_lock  = '0;
        end else begin
          w_next_lock = r_lock_cnt + LOCK_W'(1);
        end
      end
      ST_RUN: begin
        if (w_step == STEP_ILLEGAL) begin
          w_set_error  = 1'b1;
          w_next_state = ST_SYNC;
          w_next_lock  = '0;
        end else if (w_wrap_up) begin
          w_next_wrap = r_wrap_cnt + EXT_W'(1);
        end else if (w_wrap_down) begin
          w_next_wrap = r_wrap_cnt - EXT_W'(1);
        end
      end
      default: w_next_state = ST_SYNC;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_SYNC;
      r_lock_cnt <= '0;
      r_wrap_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_lock_cnt <= w_next_lock;
      r_wrap_cnt <= w_next_wrap;
      if (w_set_error) r_error <= 1'b1;
    end
  end

  // Wrap applied combinationally so count_ext never shows a stale upper half.
  assign count_ext  = {w_next_wrap, r_q_s};
  assign wrap_pulse = (r_state == ST_RUN) && (w_wrap_up || w_wrap_down);
  assign locked     = (r_state == ST_RUN);
  assign error      = r_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overrun   <= 1'b0;
    end else if (snap_req && (!r_out_valid || out_ready)) begin
      r_out_valid <= 1'b1;
      r_out_data  <= count_ext;
    end else if (snap_req) begin
      r_overrun   <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_jk_count_monitor.sv
// ============================================================================
// tb_jk_count_monitor: directed self-checking bench for jk_count_monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jk_count_monitor;

  logic        clock;
  logic        reset;
  logic [3:0]  q;
  logic [3:0]  q_bar;
  logic        snap_req;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic [11:0] count_ext;
  logic        wrap_pulse;
  logic        locked;
  logic        error;
  logic        overrun;

  int vectors    = 0;
  int miscompares = 0;

  jk_count_monitor dut (
    .clock      (clock),
    .reset      (reset),
    .q          (q),
    .q_bar      (q_bar),
    .snap_req   (snap_req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .count_ext  (count_ext),
    .wrap_pulse (wrap_pulse),
    .locked     (locked),
    .error      (error),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_q(input logic [3:0] v);
    q     = v;
    q_bar = ~v;
  endtask

  task automatic reset_and_lock(input logic [3:0] v);
    @(negedge clock);
    reset = 1'b0;
    set_q(v);
    @(negedge clock);
    reset = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; set_q(4'h0); snap_req = 1'b0; out_ready = 1'b0;
    #3;
    vectors++;
    if ({out_valid, out_data, count_ext, wrap_pulse, locked, error, overrun} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0",
               {out_valid, out_data, count_ext, wrap_pulse, locked, error, overrun});
    end
    @(negedge clock);
    reset = 1'b1;
    tick(); tick();
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++; $display("FAIL lock_early: got %b required 0", locked);
    end
    tick();
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++; $display("FAIL lock_after_3: got %b required 1", locked);
    end
    vectors++;
    if (count_ext !== 12'h000 || error !== 1'b0) begin
      miscompares++; $display("FAIL lock_state: got count %h err %b required 000 0", count_ext, error);
    end
  endtask

  task automatic test_up_wrap();
    int pulses = 0;
    for (int v = 1; v < 16; v++) begin
      set_q(4'(v));
      tick();
      if (wrap_pulse) pulses++;
      vectors++;
      if (count_ext !== {8'h00, 4'(v)}) begin
        miscompares++; $display("FAIL up_count: got %h required %h", count_ext, {8'h00, 4'(v)});
      end
    end
    set_q(4'h0);
    tick();
    if (wrap_pulse) pulses++;
    vectors++;
    if (wrap_pulse !== 1'b1 || count_ext !== 12'h010) begin
      miscompares++; $display("FAIL up_wrap: got pulse %b count %h required 1 010", wrap_pulse, count_ext);
    end
    tick();
    if (wrap_pulse) pulses++;
    vectors++;
    if (pulses !== 1 || count_ext !== 12'h010) begin
      miscompares++; $display("FAIL up_wrap_once: got pulses %0d count %h required 1 010", pulses, count_ext);
    end
  endtask

  task automatic test_down_wrap();
    set_q(4'hF);
    tick();
    vectors++;
    if (wrap_pulse !== 1'b1 || count_ext !== 12'h00F) begin
      miscompares++; $display("FAIL down_wrap: got pulse %b count %h required 1 00f", wrap_pulse, count_ext);
    end
    set_q(4'h0);
    tick();
    vectors++;
    if (wrap_pulse !== 1'b1 || count_ext !== 12'h010) begin
      miscompares++; $display("FAIL rewrap_up: got pulse %b count %h required 1 010", wrap_pulse, count_ext);
    end
    tick();
    vectors++;
    if (wrap_pulse !== 1'b0 || locked !== 1'b1) begin
      miscompares++; $display("FAIL hold_after_wrap: got pulse %b locked %b required 0 1", wrap_pulse, locked);
    end
  endtask

  task automatic test_illegal_step();
    set_q(4'h1); tick();
    set_q(4'h2); tick();
    set_q(4'h3); tick();
    set_q(4'h7); tick();
    vectors++;
    if (error !== 1'b0 || locked !== 1'b1 || count_ext !== 12'h017) begin
      miscompares++;
      $display("FAIL jump_sampled: got err %b locked %b count %h required 0 1 017", error, locked, count_ext);
    end
    tick();
    vectors++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      miscompares++; $display("FAIL jump_error: got err %b locked %b required 1 0", error, locked);
    end
    tick();
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++; $display("FAIL relock_early: got %b required 0", locked);
    end
    tick();
    vectors++;
    if (locked !== 1'b1 || count_ext !== 12'h017) begin
      miscompares++; $display("FAIL relock: got locked %b count %h required 1 017", locked, count_ext);
    end
  endtask

  task automatic test_inconsistent();
    reset_and_lock(4'h7);
    vectors++;
    if (locked !== 1'b1 || error !== 1'b0 || count_ext !== 12'h007) begin
      miscompares++;
      $display("FAIL lock_at_7: got locked %b err %b count %h required 1 0 007", locked, error, count_ext);
    end
    q_bar = 4'h7;
    tick();
    set_q(4'h7);
    tick();
    vectors++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      miscompares++; $display("FAIL bad_qbar: got err %b locked %b required 1 0", error, locked);
    end
    tick(); tick();
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++; $display("FAIL relock_qbar: got %b required 1", locked);
    end
    q_bar = 4'bxxxx;
    tick();
    set_q(4'h7);
    tick();
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++; $display("FAIL x_qbar: got locked %b required 0", locked);
    end
    tick(); tick();
    vectors++;
    if (locked !== 1'b1 || count_ext !== 12'h007) begin
      miscompares++; $display("FAIL relock_x: got locked %b count %h required 1 007", locked, count_ext);
    end
  endtask

  task automatic test_snapshot();
    out_ready = 1'b0;
    snap_req  = 1'b1;
    tick();
    snap_req  = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'h007 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL snap_first: got v %b data %h ovr %b required 1 007 0", out_valid, out_data, overrun);
    end
    set_q(4'h8);
    tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || out_data !== 12'h007 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL snap_overrun: got ovr %b data %h v %b required 1 007 1", overrun, out_data, out_valid);
    end
    snap_req  = 1'b1;
    out_ready = 1'b1;
    tick();
    snap_req  = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'h008) begin
      miscompares++; $display("FAIL snap_replace: got v %b data %h required 1 008", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL snap_drain: got v %b required 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_data, count_ext, wrap_pulse, locked, error, overrun} !== 30'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h required 0",
               {out_valid, out_data, count_ext, wrap_pulse, locked, error, overrun});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_illegal_step();
    test_inconsistent();
    test_snapshot();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
